// File: rtl/amba_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amba_axil_pkg
// Description : Shared types and constants for the AXI4-Lite master.
// Revision    : 1.0 - initial release
// ============================================================================
package amba_axil_pkg;

    localparam int C_PROT_W = 3;
    localparam int C_RESP_W = 2;

    localparam logic [C_PROT_W-1:0] C_PROT_DEFAULT = 3'b000;

    typedef enum logic [C_RESP_W-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axil_master_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : axil_master_watchdog
// Description : Cycle counter that flags a bus transaction stuck too long.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_master_watchdog
    import amba_axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic   clk,
    input  logic   rst,
    input  state_t i_state,
    output logic   o_expired
);

    localparam int              C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              r_last_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_CNT_W-1:0]  w_cnt;
    logic                w_active;

    assign w_active = (i_state == ST_WR_REQ) || (i_state == ST_WR_RESP) ||
                      (i_state == ST_RD_REQ) || (i_state == ST_RD_DATA);

    // The first cycle in a new state counts as zero, so each state gets a full budget.
    assign w_cnt     = (i_state != r_last_state) ? '0 : r_cnt;
    assign o_expired = w_active && (w_cnt == C_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_state <= ST_IDLE;
            r_cnt        <= '0;
        end else begin
            r_last_state <= i_state;
            r_cnt        <= w_active ? (w_cnt + 1'b1) : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/amba_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : amba_axi4_lite_master
// Description : Single-outstanding AXI4-Lite initiator driven by a cmd/rsp port.
//               Optional watchdog abort compiled in with AXIL_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module amba_axi4_lite_master
    import amba_axil_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_W-1:0]     i_cmd_addr,
    input  logic [DATA_W-1:0]     i_cmd_wdata,
    input  logic [DATA_W/8-1:0]   i_cmd_wstrb,
    input  logic [C_PROT_W-1:0]   i_cmd_prot,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_write,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic [C_RESP_W-1:0]   o_rsp_resp,
    output logic                  o_awvalid,
    output logic [ADDR_W-1:0]     o_awaddr,
    output logic [C_PROT_W-1:0]   o_awprot,
    input  logic                  i_awready,
    output logic                  o_wvalid,
    output logic [DATA_W-1:0]     o_wdata,
    output logic [DATA_W/8-1:0]   o_wstrb,
    input  logic                  i_wready,
    input  logic                  i_bvalid,
    input  logic [C_RESP_W-1:0]   i_bresp,
    output logic                  o_bready,
    output logic                  o_arvalid,
    output logic [ADDR_W-1:0]     o_araddr,
    output logic [C_PROT_W-1:0]   o_arprot,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    input  logic [DATA_W-1:0]     i_rdata,
    input  logic [C_RESP_W-1:0]   i_rresp,
    output logic                  o_rready
);

    localparam int C_STRB_W = DATA_W / 8;

    state_t                r_state,     w_state_nxt;
    logic                  r_cmd_ready, w_cmd_ready_nxt;
    logic                  r_awvalid,   w_awvalid_nxt;
    logic                  r_wvalid,    w_wvalid_nxt;
    logic                  r_bready,    w_bready_nxt;
    logic                  r_arvalid,   w_arvalid_nxt;
    logic                  r_rready,    w_rready_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic                  r_aw_done,   w_aw_done_nxt;
    logic                  r_w_done,    w_w_done_nxt;
    logic                  r_write,     w_write_nxt;
    logic [ADDR_W-1:0]     r_addr,      w_addr_nxt;
    logic [DATA_W-1:0]     r_wdata,     w_wdata_nxt;
    logic [C_STRB_W-1:0]   r_wstrb,     w_wstrb_nxt;
    logic [C_PROT_W-1:0]   r_prot,      w_prot_nxt;
    logic                  r_rsp_write, w_rsp_write_nxt;
    logic [DATA_W-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
    logic [C_RESP_W-1:0]   r_rsp_resp,  w_rsp_resp_nxt;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_timeout;

`ifdef AXIL_MASTER_TIMEOUT_EN
    axil_master_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (ACLK),
        .rst       (ARST),
        .i_state   (r_state),
        .o_expired (w_timeout)
    );
`else
    // Watchdog compiled out: a stalled responder stalls the master indefinitely.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign w_aw_hs = r_awvalid && i_awready;
    assign w_w_hs  = r_wvalid  && i_wready;

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_write_nxt     = r_write;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_prot_nxt      = r_prot;
        w_rsp_write_nxt = r_rsp_write;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (i_cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_write_nxt     = i_cmd_write;
                    w_addr_nxt      = i_cmd_addr;
                    w_wdata_nxt     = i_cmd_wdata;
                    w_wstrb_nxt     = i_cmd_wstrb;
                    w_prot_nxt      = i_cmd_prot;
                    if (i_cmd_write) begin
                        w_state_nxt   = ST_WR_REQ;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                    end else begin
                        w_state_nxt   = ST_RD_REQ;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt  = ST_WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (i_bvalid && r_bready) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_write_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = i_bresp;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (i_arready && r_arvalid) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (i_rvalid && r_rready) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_write_nxt = 1'b0;
                    w_rsp_rdata_nxt = i_rdata;
                    w_rsp_resp_nxt  = i_rresp;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_ready_nxt = 1'b0;
                w_awvalid_nxt   = 1'b0;
                w_wvalid_nxt    = 1'b0;
                w_bready_nxt    = 1'b0;
                w_arvalid_nxt   = 1'b0;
                w_rready_nxt    = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase

        // Debug abort: drop every handshake and report DECERR to the command side.
        if (w_timeout) begin
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_write_nxt = r_write;
            w_rsp_rdata_nxt = '0;
            w_rsp_resp_nxt  = DECERR;
            w_state_nxt     = ST_RSP;
        end
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_prot      <= C_PROT_DEFAULT;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_prot      <= w_prot_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_write = r_rsp_write;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_resp  = r_rsp_resp;
    assign o_awvalid   = r_awvalid;
    assign o_awaddr    = r_addr;
    assign o_awprot    = r_prot;
    assign o_wvalid    = r_wvalid;
    assign o_wdata     = r_wdata;
    assign o_wstrb     = r_wstrb;
    assign o_bready    = r_bready;
    assign o_arvalid   = r_arvalid;
    assign o_araddr    = r_addr;
    assign o_arprot    = r_prot;
    assign o_rready    = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_amba_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_amba_axi4_lite_master
// Description : Directed bench with a small 4-word register-file responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amba_axi4_lite_master;

    logic        ACLK;
    logic        ARST;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [31:0] i_cmd_addr, i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic [2:0]  i_cmd_prot;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_write;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic        o_awvalid, i_awready, o_wvalid, i_wready;
    logic [31:0] o_awaddr, o_wdata, o_araddr;
    logic [2:0]  o_awprot, o_arprot;
    logic [3:0]  o_wstrb;
    logic        i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
    logic [1:0]  i_bresp, i_rresp;
    logic [31:0] i_rdata;

    amba_axi4_lite_master dut (
        .ACLK(ACLK), .ARST(ARST),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .i_cmd_prot(i_cmd_prot), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_write(o_rsp_write), .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
        .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .o_awprot(o_awprot), .i_awready(i_awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .o_arprot(o_arprot), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rresp(i_rresp), .o_rready(o_rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Responder: 4 legal words at addresses 0..3, SLVERR elsewhere; B/R one cycle after accept.
    logic        aw_rdy_en, w_rdy_en, ar_rdy_en, r_en;
    logic [31:0] mem [4];
    logic        aw_got, w_got, r_pend;
    logic [31:0] aw_addr_cap, wd_cap, rd_addr_cap;
    logic [3:0]  ws_cap;
    logic [2:0]  aw_prot_cap, ar_prot_cap;

    assign i_awready = aw_rdy_en;
    assign i_wready  = w_rdy_en;
    assign i_arready = ar_rdy_en;

    always @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            i_bvalid <= 1'b0; i_bresp <= 2'b00;
            i_rvalid <= 1'b0; i_rdata <= '0; i_rresp <= 2'b00;
            aw_addr_cap <= '0; wd_cap <= '0; ws_cap <= '0; rd_addr_cap <= '0;
            aw_prot_cap <= '0; ar_prot_cap <= '0;
        end else begin
            if (o_awvalid && i_awready) begin
                aw_got <= 1'b1; aw_addr_cap <= o_awaddr; aw_prot_cap <= o_awprot;
            end
            if (o_wvalid && i_wready) begin
                w_got <= 1'b1; wd_cap <= o_wdata; ws_cap <= o_wstrb;
            end
            if (aw_got && w_got && !i_bvalid) begin
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                i_bvalid <= 1'b1;
                if (aw_addr_cap < 32'd4) begin
                    i_bresp <= 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (ws_cap[b]) mem[aw_addr_cap[1:0]][8*b +: 8] <= wd_cap[8*b +: 8];
                end else begin
                    i_bresp <= 2'b10;
                end
            end
            if (i_bvalid && o_bready) i_bvalid <= 1'b0;
            if (o_arvalid && i_arready) begin
                r_pend <= 1'b1; rd_addr_cap <= o_araddr; ar_prot_cap <= o_arprot;
            end
            if (r_pend && r_en && !i_rvalid) begin
                r_pend   <= 1'b0;
                i_rvalid <= 1'b1;
                i_rdata  <= (rd_addr_cap < 32'd4) ? mem[rd_addr_cap[1:0]] : 32'h0;
                i_rresp  <= (rd_addr_cap < 32'd4) ? 2'b00 : 2'b10;
            end
            if (i_rvalid && o_rready) i_rvalid <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p);
        int w;
        w = 0;
        i_cmd_write = wr; i_cmd_addr = a; i_cmd_wdata = d; i_cmd_wstrb = s; i_cmd_prot = p;
        i_cmd_valid = 1'b1;
        while (!o_cmd_ready && w < 20) begin
            @(posedge ACLK); #1; w++;
        end
        if (!o_cmd_ready) check("cmd_accept_timeout", {31'b0, o_cmd_ready}, 32'd1);
        @(posedge ACLK); #1;
        i_cmd_valid = 1'b0;
    endtask

    // Called in the first cycle after the command handshake; lat counts that cycle as 1.
    task automatic wait_rsp(output int lat, output logic rdy_seen, output logic [2:0] first_v);
        lat      = 1;
        rdy_seen = 1'b0;
        first_v  = {o_awvalid, o_wvalid, o_arvalid};
        while (!o_rsp_valid && lat < 400) begin
            rdy_seen |= o_cmd_ready;
            @(posedge ACLK); #1; lat++;
        end
        rdy_seen |= o_cmd_ready;
        if (!o_rsp_valid) check("rsp_wait_timeout", {31'b0, o_rsp_valid}, 32'd1);
    endtask

    task automatic consume();
        i_rsp_ready = 1'b1;
        @(posedge ACLK); #1;
        i_rsp_ready = 1'b0;
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    int          lat;
    logic        rdy_seen, stable, rsp_seen;
    logic [2:0]  first_v;
    logic [35:0] snap;

    initial begin
        vecs[0] = '{1'b1, 32'h0, 32'h0000aaaa, 4'hf, 3'b000, 2'b00, 32'h0};
        vecs[1] = '{1'b1, 32'h1, 32'h0000bbbb, 4'hf, 3'b010, 2'b00, 32'h0};
        vecs[2] = '{1'b0, 32'h1, 32'h0,        4'h0, 3'b001, 2'b00, 32'h0000bbbb};
        vecs[3] = '{1'b1, 32'h4, 32'h11111111, 4'hf, 3'b000, 2'b10, 32'h0};
        vecs[4] = '{1'b0, 32'h0, 32'h0,        4'h0, 3'b000, 2'b00, 32'h0000aaaa};
        vecs[5] = '{1'b1, 32'h0, 32'h12345678, 4'h3, 3'b110, 2'b00, 32'h0};
        vecs[6] = '{1'b0, 32'h0, 32'h0,        4'h0, 3'b111, 2'b00, 32'h00005678};
        vecs[7] = '{1'b0, 32'h7, 32'h0,        4'h0, 3'b000, 2'b10, 32'h0};

        ARST = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
        i_cmd_wstrb = '0; i_cmd_prot = '0; i_rsp_ready = 1'b0;
        aw_rdy_en = 1'b1; w_rdy_en = 1'b1; ar_rdy_en = 1'b1; r_en = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check("reset_outputs_zero",
              {31'b0, |{o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
                        o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_rdata, o_awaddr,
                        o_awprot, o_wdata, o_wstrb, o_araddr, o_arprot}}, 32'd0);
        ARST = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot);
            wait_rsp(lat, rdy_seen, first_v);
            check($sformatf("v%0d_first_valids", i), {29'b0, first_v},
                  vecs[i].wr ? 32'd6 : 32'd1);
            check($sformatf("v%0d_latency", i), lat, 32'd4);
            check($sformatf("v%0d_cmd_ready_low", i), {31'b0, rdy_seen}, 32'd0);
            check($sformatf("v%0d_resp", i), {30'b0, o_rsp_resp}, {30'b0, vecs[i].exp_resp});
            check($sformatf("v%0d_rdata", i), o_rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_write", i), {31'b0, o_rsp_write}, {31'b0, vecs[i].wr});
            check($sformatf("v%0d_prot", i), {29'b0, vecs[i].wr ? aw_prot_cap : ar_prot_cap},
                  {29'b0, vecs[i].prot});
            consume();
        end

        // AWREADY held off for three cycles while W is accepted immediately.
        aw_rdy_en = 1'b0;
        send_cmd(1'b1, 32'h2, 32'h0000cccc, 4'hf, 3'b000);
        check("dly_c1_valids", {30'b0, o_awvalid, o_wvalid}, 32'd3);
        @(posedge ACLK); #1;
        check("dly_c2_valids", {29'b0, o_awvalid, o_wvalid, o_bready}, 32'd4);
        check("dly_c2_awaddr", o_awaddr, 32'h2);
        @(posedge ACLK); #1;
        check("dly_c3_valids", {29'b0, o_awvalid, o_wvalid, o_bready}, 32'd4);
        check("dly_c3_awaddr", o_awaddr, 32'h2);
        @(posedge ACLK); #1;
        aw_rdy_en = 1'b1;
        check("dly_c4_valids", {29'b0, o_awvalid, o_wvalid, o_bready}, 32'd4);
        @(posedge ACLK); #1;
        check("dly_c5_valids", {29'b0, o_awvalid, o_wvalid, o_bready}, 32'd1);
        wait_rsp(lat, rdy_seen, first_v);
        check("dly_resp", {30'b0, o_rsp_resp}, 32'd0);
        consume();

        // Response held back five cycles; fields must not move.
        send_cmd(1'b0, 32'h2, 32'h0, 4'h0, 3'b000);
        wait_rsp(lat, rdy_seen, first_v);
        check("hold_rdata", o_rsp_rdata, 32'h0000cccc);
        snap   = {o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_rdata};
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge ACLK); #1;
            if ({o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_rdata} !== snap || o_cmd_ready)
                stable = 1'b0;
        end
        check("hold_stable", {31'b0, stable}, 32'd1);
        consume();
        check("hold_after_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        check("hold_after_cmd_ready", {31'b0, o_cmd_ready}, 32'd1);

        // Asynchronous reset while waiting for read data.
        r_en = 1'b0;
        send_cmd(1'b0, 32'h3, 32'h0, 4'h0, 3'b101);
        @(posedge ACLK); #1;
        check("rst_in_rd_data_rready", {30'b0, o_rready, o_arvalid}, 32'd2);
        #2 ARST = 1'b1;
        #1;
        check("rst_async_zero",
              {31'b0, |{o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
                        o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_rdata, o_awaddr,
                        o_awprot, o_wdata, o_wstrb, o_araddr, o_arprot}}, 32'd0);
        @(posedge ACLK); #1;
        ARST = 1'b0;
        r_en = 1'b1;
        rsp_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge ACLK); #1;
            rsp_seen |= o_rsp_valid;
        end
        check("rst_no_response", {31'b0, rsp_seen}, 32'd0);
        check("rst_back_idle", {31'b0, o_cmd_ready}, 32'd1);

`ifdef AXIL_MASTER_TIMEOUT_EN
        // ARREADY never arrives: 256 cycles in RD_REQ, then DECERR.
        ar_rdy_en = 1'b0;
        send_cmd(1'b0, 32'h1, 32'h0, 4'h0, 3'b000);
        wait_rsp(lat, rdy_seen, first_v);
        check("to_latency", lat, 32'd257);
        check("to_resp", {30'b0, o_rsp_resp}, 32'd3);
        check("to_rdata", o_rsp_rdata, 32'h0);
        check("to_arvalid", {31'b0, o_arvalid}, 32'd0);
        consume();
        ar_rdy_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/amba_axi4_lite_master.md
Name: amba_axi4_lite_master

Overview:
- Synthesizable AXI4-Lite initiator; the manager-side counterpart of the amba_axi4_lite responder that fronts the regfile.
- Accepts single read/write commands on a simple valid/ready command port and runs one AXI4-Lite transaction per command.
- Returns the response (read data + RESP) on a valid/ready response port.
- Used by the datapath/sequencer to program and poll the register file without a bench driving the bus.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; STRB width = DATA_W/8.
- TIMEOUT_CYCLES, 256, watchdog limit; used only when the optional feature is compiled in.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARST  in  1  asynchronous reset, active-high.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_write  in  1  1=write, 0=read.
- i_cmd_addr  in  ADDR_W  target address.
- i_cmd_wdata  in  DATA_W  write data.
- i_cmd_wstrb  in  DATA_W/8  write strobes.
- i_cmd_prot  in  3  AxPROT value.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  response consumed.
- o_rsp_write  out  1  response belongs to a write.
- o_rsp_rdata  out  DATA_W  read data; 0 for writes.
- o_rsp_resp  out  2  BRESP/RRESP.
- o_awvalid/o_awaddr/o_awprot  out  1/ADDR_W/3  AW channel; i_awready in 1.
- o_wvalid/o_wdata/o_wstrb  out  1/DATA_W/DATA_W/8  W channel; i_wready in 1.
- i_bvalid/i_bresp  in  1/2  B channel; o_bready out 1.
- o_arvalid/o_araddr/o_arprot  out  1/ADDR_W/3  AR channel; i_arready in 1.
- i_rvalid/i_rdata/i_rresp  in  1/DATA_W/2  R channel; o_rready out 1.

Behaviour:
- Reset (ARST high, async):
  - state=IDLE.
  - All valid/ready outputs 0: o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid.
  - All data/addr/resp outputs 0.
  - Reset mid-transaction abandons the transaction at once; no response is produced.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid&&o_cmd_ready, all command fields are registered.
  - Write goes to WR_REQ with o_awvalid=o_wvalid=1 on the next cycle.
  - Read goes to RD_REQ with o_arvalid=1 on the next cycle.
- WR_REQ:
  - AW and W are issued together and tracked by separate done flags.
  - o_awvalid drops the cycle after the AW handshake; o_wvalid drops the cycle after the W handshake. Each is independent of the other.
  - Once both handshakes are done, go to WR_RESP with o_bready=1.
  - Both handshakes in the same cycle go straight to WR_RESP.
- WR_RESP: on i_bvalid&&o_bready, latch i_bresp, o_rsp_write=1, o_rsp_rdata=0, clear o_bready, go to RSP.
- RD_REQ: on i_arready&&o_arvalid, clear o_arvalid, set o_rready=1, go to RD_DATA.
- RD_DATA: on i_rvalid&&o_rready, latch i_rdata/i_rresp, o_rsp_write=0, clear o_rready, go to RSP.
- RSP:
  - o_rsp_valid=1 and rsp fields held stable until i_rsp_ready, then go to IDLE.
  - A new command can be accepted no earlier than the cycle after the response handshake.
- Protocol rules:
  - Valids never depend combinationally on readys.
  - Address/data/strb/prot stay stable while the matching valid is high.
  - Exactly one outstanding transaction at any time.
- Latency: minimum write = cmd handshake → AW/W valid (+1) → B (+2) → rsp_valid (+3). Minimum read has the same shape.
- Illegal addresses are not checked here; any RESP value, including SLVERR 2'b10, passes through unchanged.

Optional Feature:
- Macro: AXIL_MASTER_TIMEOUT_EN.
- Enabled:
  - A counter clears on every state change and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches TIMEOUT_CYCLES, all AXI valids/readys are dropped, o_rsp_resp=2'b11 (DECERR) and o_rsp_rdata=0, and the state goes to RSP.
  - This is a debug-only abort; the responder must be reset afterwards.
- Disabled: no counter; the master waits indefinitely for handshakes.

Decomposition:
- Package amba_axil_pkg:
  - resp_t enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - master state_t enum.
  - Default PROT constant 3'b000.
  - Width localparams.
- One natural sub-module, axil_master_watchdog: the timeout counter, instantiated only under AXIL_MASTER_TIMEOUT_EN.

Test Plan:
- Write addr 0x0, data 0xaaaa, strb 0xf, responder always ready, BRESP=0 → AW/W valid one cycle after cmd handshake; o_rsp_valid with resp=0, write=1, exactly 4 cycles after the cmd handshake.
- Write 0x1/0xbbbb then read 0x1 via regfile responder → read response rdata=0x0000bbbb, resp=0; o_cmd_ready low throughout both transactions.
- AWREADY delayed 3 cycles, WREADY immediate → o_wvalid drops after 1 cycle while o_awvalid is held with a stable address; o_bready rises only after both handshakes.
- Write to illegal address 0x4 with BRESP=2'b10 → o_rsp_resp=2'b10; next command still accepted.
- i_rsp_ready held low 5 cycles → o_rsp_valid and fields stable for 5 cycles; o_cmd_ready stays 0 until the response is consumed.
- ARST pulse while in RD_DATA → all outputs 0 asynchronously, state IDLE, no response. Under AXIL_MASTER_TIMEOUT_EN with ARREADY never asserted → DECERR response after 256 cycles.
